// File: rtl/mpe_result_packer_if.sv
// Packed-line write port between mpe_result_packer (master) and the output line RAM (slave).
interface mpe_result_packer_if #(
  parameter int LINE_W = 512,
  parameter int ADDR_W = 8
) ();
  logic [LINE_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_addr, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_addr, input wr_valid, output wr_ready);
endinterface

// File: rtl/mpe_result_packer.sv
// Requantizes PE results, packs PACK lanes per line and queues lines for the output RAM.
// Optional build macro MPE_PACK_RELU_EN: clamp negative lanes to zero before packing.
module mpe_result_packer #(
  parameter int RES_W      = 32,
  parameter int OUT_W      = 16,
  parameter int PACK       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [15:0]         cfg_len,
  input  logic [4:0]          cfg_shift,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [RES_W-1:0]    mpe_result,
  input  logic                mpe_vld,
  mpe_result_packer_if.master wr_if,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  localparam int LINE_W = PACK * OUT_W;
  localparam int LANE_W = $clog2(PACK);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic signed [RES_W:0] SAT_MAX = {{(RES_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RES_W:0] SAT_MIN = {{(RES_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Round-half-up, arithmetic shift, saturate; one extra bit keeps the rounding add from wrapping.
  function automatic logic [OUT_W-1:0] quantize(input logic [RES_W-1:0] res, input logic [4:0] sh);
    logic signed [RES_W:0] ext;
    logic signed [RES_W:0] rnd;
    logic [OUT_W-1:0]      q;
    ext = $signed({res[RES_W-1], res});
    if (sh != 5'd0) rnd = {{RES_W{1'b0}}, 1'b1} << (sh - 5'd1);
    else            rnd = '0;
    ext = (ext + rnd) >>> sh;
    if (ext > SAT_MAX)      q = SAT_MAX[OUT_W-1:0];
    else if (ext < SAT_MIN) q = SAT_MIN[OUT_W-1:0];
    else                    q = ext[OUT_W-1:0];
`ifdef MPE_PACK_RELU_EN
    if (q[OUT_W-1]) q = '0;
    else            q = q;
`endif
    return q;
  endfunction

  state_t              state_r, state_s;
  logic [15:0]         len_r, res_cnt_r;
  logic [4:0]          shift_r;
  logic [ADDR_W-1:0]   base_r, line_idx_r;
  logic [LANE_W-1:0]   lane_cnt_r;
  logic [LINE_W-1:0]   line_r, line_s;
  logic                overflow_r;
  logic [LINE_W-1:0]   fifo_data_r [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]      fifo_cnt_r;
  logic [OUT_W-1:0]    quant_s;
  logic                start_s, sample_s, last_s, close_s, pop_s, full_s, push_s, drop_s;
  logic                busy_s, done_s;

  assign quant_s  = quantize(mpe_result, shift_r);
  assign start_s  = cfg_start && (state_r == ST_IDLE);
  assign sample_s = mpe_vld && (state_r == ST_COLLECT);
  assign last_s   = sample_s && (res_cnt_r == (len_r - 16'd1));
  assign close_s  = sample_s && ((lane_cnt_r == LANE_LAST) || last_s);
  assign pop_s    = (fifo_cnt_r != '0) && wr_if.wr_ready;
  assign full_s   = (fifo_cnt_r == CNT_FULL);
  // A pop on the same edge frees the slot the closing line needs.
  assign push_s   = close_s && (!full_s || pop_s);
  assign drop_s   = close_s && full_s && !pop_s;

  // Current line with the incoming quantized result merged into its lane.
  always_comb begin
    line_s = line_r;
    for (int i = 0; i < PACK; i++) begin
      if (lane_cnt_r == LANE_W'(i)) line_s[OUT_W*i +: OUT_W] = quant_s;
      else                          line_s[OUT_W*i +: OUT_W] = line_r[OUT_W*i +: OUT_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) state_s = (cfg_len != 16'd0) ? ST_COLLECT : ST_DONE;
        else           state_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (last_s) state_s = ST_DRAIN;
        else        state_s = ST_COLLECT;
      end
      ST_DRAIN: begin
        if (fifo_cnt_r == '0) state_s = ST_DONE;
        else                  state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
      ST_COLLECT: begin busy_s = 1'b1; done_s = 1'b0; end
      ST_DRAIN:   begin busy_s = 1'b1; done_s = 1'b0; end
      ST_DONE:    begin busy_s = 1'b1; done_s = 1'b1; end
      default:    begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Job configuration, result/lane counters and the line being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= '0;
      shift_r    <= '0;
      base_r     <= '0;
      res_cnt_r  <= '0;
      lane_cnt_r <= '0;
      line_r     <= '0;
      line_idx_r <= '0;
    end else if (start_s) begin
      len_r      <= cfg_len;
      shift_r    <= cfg_shift;
      base_r     <= cfg_base_addr;
      res_cnt_r  <= '0;
      lane_cnt_r <= '0;
      line_r     <= '0;
      line_idx_r <= '0;
    end else if (close_s) begin
      res_cnt_r  <= res_cnt_r + 16'd1;
      lane_cnt_r <= '0;
      line_r     <= '0;
      line_idx_r <= line_idx_r + ADDR_W'(1);
    end else if (sample_s) begin
      res_cnt_r  <= res_cnt_r + 16'd1;
      lane_cnt_r <= lane_cnt_r + LANE_W'(1);
      line_r     <= line_s;
    end
  end

  // Sticky drop flag, cleared when a new job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow_r <= 1'b0;
    else if (start_s) overflow_r <= 1'b0;
    else if (drop_s)  overflow_r <= 1'b1;
  end

  // Packed-line FIFO; a dropped line still consumes its address index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
        fifo_addr_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= line_s;
        fifo_addr_r[wr_ptr_r] <= base_r + line_idx_r;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  assign wr_if.wr_valid = (fifo_cnt_r != '0);
  assign wr_if.wr_data  = fifo_data_r[rd_ptr_r];
  assign wr_if.wr_addr  = fifo_addr_r[rd_ptr_r];
  assign busy           = busy_s;
  assign done           = done_s;
  assign overflow       = overflow_r;
endmodule
